// File: rtl/mult_seq_param.sv
// Sequential multiplier that builds an A_W x B_W product from A_CHUNK x B_CHUNK
// partial products, one per cycle, with optional two's-complement operands.
module mult_seq_param #(
    parameter int A_W     = 32,
    parameter int B_W     = 32,
    parameter int A_CHUNK = 8,
    parameter int B_CHUNK = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               busy,
    output logic               done,
    output logic [A_W+B_W-1:0] product
);

    localparam int NA  = A_W / A_CHUNK;
    localparam int NB  = B_W / B_CHUNK;
    localparam int PW  = A_W + B_W;
    localparam int PPW = A_CHUNK + B_CHUNK;
    localparam int IW  = (NA > 1) ? $clog2(NA) : 1;
    localparam int JW  = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(NA - 1);
    localparam logic [JW-1:0] J_LAST = JW'(NB - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state;
    state_t          nextState;
    logic [A_W-1:0]  aMag;
    logic [B_W-1:0]  bMag;
    logic            resSign;
    logic [IW-1:0]   iIdx;
    logic [JW-1:0]   jIdx;
    logic            lastSlice;
    logic [A_W-1:0]  aAbs;
    logic [B_W-1:0]  bAbs;
    logic [A_CHUNK-1:0] aSlice;
    logic [B_CHUNK-1:0] bSlice;
    logic [PPW-1:0]  partial;
    logic [PW-1:0]   partialShifted;

    // In signed mode the most negative operand negates onto itself, which read
    // as unsigned is exactly its magnitude 2^(W-1).
    assign aAbs = (signed_mode && a[A_W-1]) ? -a : a;
    assign bAbs = (signed_mode && b[B_W-1]) ? -b : b;

    assign busy      = (state != IDLE);
    assign lastSlice = (iIdx == I_LAST) && (jIdx == J_LAST);

    assign aSlice         = A_CHUNK'(aMag >> (A_CHUNK * int'(iIdx)));
    assign bSlice         = B_CHUNK'(bMag >> (B_CHUNK * int'(jIdx)));
    assign partial        = PPW'(aSlice) * PPW'(bSlice);
    assign partialShifted = PW'(partial) << (A_CHUNK * int'(iIdx) + B_CHUNK * int'(jIdx));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CALC;
            CALC:    if (lastSlice) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Slice walk runs i fastest, j slowest; the accumulated product is the
    // unsigned magnitude until FIX applies the result sign.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aMag    <= '0;
            bMag    <= '0;
            resSign <= 1'b0;
            iIdx    <= '0;
            jIdx    <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        aMag    <= aAbs;
                        bMag    <= bAbs;
                        resSign <= signed_mode & (a[A_W-1] ^ b[B_W-1]);
                        product <= '0;
                        iIdx    <= '0;
                        jIdx    <= '0;
                    end
                end
                CALC: begin
                    product <= product + partialShifted;
                    if (iIdx == I_LAST) begin
                        iIdx <= '0;
                        if (jIdx == J_LAST) begin
                            jIdx <= '0;
                        end else begin
                            jIdx <= jIdx + JW'(1);
                        end
                    end else begin
                        iIdx <= iIdx + IW'(1);
                    end
                end
                FIX: begin
                    if (resSign) begin
                        product <= -product;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench for mult_seq_param: vector table, random operands against
// a plain-arithmetic model, and hand-written multi-cycle corner sequences.
module tb_mult_seq_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    logic        sStart;
    logic        sSigned;
    logic [15:0] sA;
    logic [7:0]  sB;
    logic        sBusy;
    logic        sDone;
    logic [23:0] sProduct;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mult_seq_param u_dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    mult_seq_param #(.A_W(16), .B_W(8), .A_CHUNK(4), .B_CHUNK(8)) u_small (
        .clk(clk), .reset(reset), .start(sStart), .signed_mode(sSigned),
        .a(sA), .b(sB), .busy(sBusy), .done(sDone), .product(sProduct)
    );

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        bit          vsm;
        logic [63:0] expP;
    } vec_t;

    function automatic logic [63:0] refMain(input logic [31:0] va, input logic [31:0] vb, input bit vsm);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (vsm) begin
            sa = $signed({{32{va[31]}}, va});
            sb = $signed({{32{vb[31]}}, vb});
            return 64'(sa * sb);
        end
        return {32'd0, va} * {32'd0, vb};
    endfunction

    function automatic logic [23:0] refSmall(input logic [15:0] va, input logic [7:0] vb, input bit vsm);
        logic signed [23:0] sa;
        logic signed [23:0] sb;
        if (vsm) begin
            sa = $signed({{8{va[15]}}, va});
            sb = $signed({{16{vb[7]}}, vb});
            return 24'(sa * sb);
        end
        return {8'd0, va} * {16'd0, vb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input bit vsm);
        a = va;
        b = vb;
        signed_mode = vsm;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Operands are scrambled every busy cycle; the result must not notice.
    task automatic waitDone(output int cyc, output bit timedOut);
        cyc = 1;
        timedOut = 1'b1;
        for (int k = 0; k < 30; k++) begin
            a = $urandom;
            b = $urandom;
            signed_mode = 1'($urandom_range(0, 1));
            tick();
            if (!busy) begin
                timedOut = 1'b0;
                break;
            end
            cyc++;
        end
    endtask

    task automatic runMain(input logic [31:0] va, input logic [31:0] vb, input bit vsm,
                           input logic [63:0] expP, input string tag);
        int cyc;
        bit to;
        applyStimulus(va, vb, vsm);
        checkOutput({tag, " busy_after_start"}, 64'(busy), 64'd1);
        checkOutput({tag, " product_cleared"}, product, 64'd0);
        waitDone(cyc, to);
        checkOutput({tag, " timeout"}, 64'(to), 64'd0);
        checkOutput({tag, " busy_cycles"}, 64'(cyc), 64'd9);
        checkOutput({tag, " done"}, 64'(done), 64'd1);
        checkOutput({tag, " product"}, product, expP);
        tick();
        checkOutput({tag, " done_one_cycle"}, 64'(done), 64'd0);
        checkOutput({tag, " product_hold"}, product, expP);
    endtask

    task automatic runSmall(input logic [15:0] va, input logic [7:0] vb, input bit vsm, input string tag);
        int cyc;
        bit to;
        logic [23:0] expP;
        expP = refSmall(va, vb, vsm);
        sA = va;
        sB = vb;
        sSigned = vsm;
        sStart = 1'b1;
        tick();
        sStart = 1'b0;
        cyc = 1;
        to = 1'b1;
        for (int k = 0; k < 30; k++) begin
            sA = 16'($urandom);
            sB = 8'($urandom);
            tick();
            if (!sBusy) begin
                to = 1'b0;
                break;
            end
            cyc++;
        end
        checkOutput({tag, " timeout"}, 64'(to), 64'd0);
        checkOutput({tag, " busy_cycles"}, 64'(cyc), 64'd5);
        checkOutput({tag, " done"}, 64'(sDone), 64'd1);
        checkOutput({tag, " product"}, 64'(sProduct), 64'(expP));
    endtask

    vec_t vecs[8];

    initial begin
        int cyc;
        bit to;
        int doneSeen;
        logic [31:0] ra;
        logic [31:0] rb;
        bit rsm;

        vecs[0] = '{32'd313552739, 32'd207231267, 1'b0, 64'd64977931374290313};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vecs[5] = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000};
        vecs[6] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000};
        vecs[7] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0000000000000000};

        start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        sStart = 1'b0; sSigned = 1'b0; sA = '0; sB = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset product", product, 64'd0);
        tick();
        tick();
        reset = 1'b1;

        // First start right after release, then the fixed vector table.
        for (int i = 0; i < 8; i++) begin
            runMain(vecs[i].va, vecs[i].vb, vecs[i].vsm, vecs[i].expP, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            rsm = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = 32'h80000000;
            if (i % 7 == 0) rb = 32'hFFFFFFFF;
            runMain(ra, rb, rsm, refMain(ra, rb, rsm), $sformatf("rand%0d", i));
        end

        // A start during an operation is ignored; start held with done chains.
        applyStimulus(32'd100000, 32'd300, 1'b0);
        tick();
        tick();
        a = 32'd5; b = 32'd7; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        waitDone(cyc, to);
        checkOutput("ignore timeout", 64'(to), 64'd0);
        checkOutput("ignore done", 64'(done), 64'd1);
        checkOutput("ignore product", product, 64'd30000000);
        applyStimulus(32'd5, 32'd7, 1'b0);
        checkOutput("b2b busy", 64'(busy), 64'd1);
        checkOutput("b2b cleared", product, 64'd0);
        waitDone(cyc, to);
        checkOutput("b2b cycles", 64'(cyc), 64'd9);
        checkOutput("b2b done", 64'(done), 64'd1);
        checkOutput("b2b product", product, 64'd35);
        tick();

        // Reset mid-operation takes effect between edges and leaves no done.
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b0);
        tick();
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort product", product, 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done || busy) doneSeen++;
        end
        checkOutput("abort no_done", 64'(doneSeen), 64'd0);
        runMain(32'd3, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFF7, "after_abort");

        runSmall(16'hFFFF, 8'hFF, 1'b0, "small max");
        tick();
        for (int i = 0; i < 10; i++) begin
            runSmall(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $sformatf("small rand%0d", i));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
